// File: rtl/nfp_div_single_seq.sv
// Sequential IEEE-754 single-precision divider, radix-2 restoring, one quotient bit per clock.
// Latency 28 edges (normal) / 1 edge (special); holds result in DONE until out_ready.
module nfp_div_single_seq #(
  parameter logic [31:0] QNAN   = 32'h7FC00000,
  parameter int          N_ITER = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] nfp_in1,
  input  logic [31:0] nfp_in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] nfp_out,
  output logic        div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [25:0] quo_q;
  logic [4:0]  cnt_q;
  logic [31:0] res_q;
  logic        dz_q;

  // operand classification on the latched operands
  logic       a_s, b_s, s;
  logic [7:0] a_e, b_e;
  logic [22:0] a_m, b_m;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic       is_special, spec_dz;
  logic [31:0] spec_res;

  assign {a_s, a_e, a_m} = op_a;
  assign {b_s, b_e, b_m} = op_b;
  assign s      = a_s ^ b_s;
  assign a_nan  = (&a_e) & (|a_m);
  assign b_nan  = (&b_e) & (|b_m);
  assign a_inf  = (&a_e) & ~(|a_m);
  assign b_inf  = (&b_e) & ~(|b_m);
  assign a_zero = (a_e == 8'h00);
  assign b_zero = (b_e == 8'h00);

  always_comb begin
    is_special = 1'b1;
    spec_dz    = 1'b0;
    spec_res   = QNAN;
    if (a_nan | b_nan) begin
      spec_res = QNAN;
    end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
      spec_res = QNAN;
    end else if (b_zero & ~a_inf) begin
      spec_res = {s, 8'hFF, 23'h0};
      spec_dz  = 1'b1;
    end else if (a_inf) begin
      spec_res = {s, 8'hFF, 23'h0};
    end else if (b_inf | a_zero) begin
      spec_res = {s, 31'h0};
    end else begin
      is_special = 1'b0;
    end
  end

  // one restoring step; the pre-shift remainder always fits in 24 bits
  logic        ge;
  logic [23:0] diff;
  logic [24:0] rem_nxt;

  assign ge      = (rem_q >= {1'b0, mb_q});
  assign diff    = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
  assign rem_nxt = {diff, 1'b0};

  // normalise, round to nearest even, range check
  logic               q25, guard, sticky, rnd_up, carry;
  logic [23:0]        mant_pre;
  logic [22:0]        mant_lo;
  logic signed [9:0]  e_pre, e_fin;
  logic [31:0]        rnd_res;

  always_comb begin
    q25      = quo_q[25];
    mant_pre = q25 ? quo_q[25:2] : quo_q[24:1];
    guard    = q25 ? quo_q[1] : quo_q[0];
    sticky   = (q25 & quo_q[0]) | (|rem_q);
    rnd_up   = guard & (sticky | mant_pre[0]);
    carry    = rnd_up & (&mant_pre);
    // on carry the low bits wrap to zero, which is exactly 1.0 with e+1
    mant_lo  = mant_pre[22:0] + 23'(rnd_up);
    e_pre    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127
               - (q25 ? 10'sd0 : 10'sd1);
    e_fin    = e_pre + (carry ? 10'sd1 : 10'sd0);
    if (e_fin >= 10'sd255)
      rnd_res = {sign_q, 8'hFF, 23'h0};
    else if (e_fin <= 10'sd0)
      rnd_res = {sign_q, 31'h0};
    else
      rnd_res = {sign_q, e_fin[7:0], mant_lo};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = is_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt_q == 5'(N_ITER - 1)) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    nfp_out   = res_q;
    div_zero  = dz_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a <= nfp_in1;
            op_b <= nfp_in2;
          end
        end
        S_UNPACK: begin
          sign_q <= s;
          ea_q   <= a_e;
          eb_q   <= b_e;
          mb_q   <= {1'b1, b_m};
          rem_q  <= {2'b01, a_m};
          quo_q  <= '0;
          cnt_q  <= '0;
          if (is_special) begin
            res_q <= spec_res;
            dz_q  <= spec_dz;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[24:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        S_ROUND: begin
          res_q <= rnd_res;
          dz_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
